// File: rtl/dmem_dma_engine_pkg.sv
// dmem_dma_engine_pkg: shared widths, command modes and FSM states for the DMA engine
package dmem_dma_engine_pkg;
    localparam int ISIZE = 16;
    localparam int DSIZE = 16;
    typedef enum logic [1:0] {M_COPY, M_FILL, M_SUM, M_RSVD} mode_t;
    typedef enum logic [2:0] {S_IDLE, S_CP_RD, S_CP_WR, S_FILL, S_SUM_RD, S_SUM_TAIL, S_DONE} state_t;
endpackage

// File: rtl/dmem_dma_addr_gen.sv
// dmem_dma_addr_gen: latched bases plus running index, wrapping address sums and first/last flags
module dmem_dma_addr_gen #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] src_addr,
    output logic [AW-1:0] dst_addr,
    output logic          first,
    output logic          last
);
    logic [AW-1:0] src_r, dst_r, len_r, idx;
    always_ff @(posedge clk) begin
        if (rst) begin
            src_r <= '0;
            dst_r <= '0;
            len_r <= '0;
            idx   <= '0;
        end else if (load) begin
            src_r <= src;
            dst_r <= dst;
            len_r <= len;
            idx   <= '0;
        end else if (inc) begin
            idx <= idx + AW'(1);
        end
    end
    assign src_addr = src_r + idx;
    assign dst_addr = dst_r + idx;
    assign first    = idx == '0;
    assign last     = idx == len_r - AW'(1);
endmodule

// File: rtl/dmem_dma_engine.sv
// dmem_dma_engine: data-memory bus master performing COPY, FILL and SUM block operations
module dmem_dma_engine
    import dmem_dma_engine_pkg::*;
#(
    parameter int AW = ISIZE,
    parameter int DW = DSIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    state_t        state, state_nx;
    logic [DW-1:0] fill_r, acc, acc_nx;
    logic          load, inc, first, last;
    logic [AW-1:0] src_addr, dst_addr;

    dmem_dma_addr_gen #(.AW(AW)) u_addr_gen (
        .clk(clk), .rst(rst), .load(load), .inc(inc),
        .src(src), .dst(dst), .len(len),
        .src_addr(src_addr), .dst_addr(dst_addr), .first(first), .last(last)
    );

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        inc       = 1'b0;
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        load      = (state == S_IDLE) && start;
        case (state)
            S_IDLE: if (start) begin
                acc_nx   = '0;
                state_nx = (len == '0 || mode_t'(mode) == M_RSVD) ? S_DONE :
                           mode_t'(mode) == M_COPY ? S_CP_RD :
                           mode_t'(mode) == M_FILL ? S_FILL : S_SUM_RD;
            end
            S_CP_RD: begin
                mem_addr = src_addr;
                state_nx = S_CP_WR;
            end
            S_CP_WR: begin
                mem_addr  = dst_addr;
                mem_wen   = 1'b1;
                mem_wdata = mem_rdata;
                inc       = 1'b1;
                state_nx  = last ? S_DONE : S_CP_RD;
            end
            S_FILL: begin
                mem_addr  = dst_addr;
                mem_wen   = 1'b1;
                mem_wdata = fill_r;
                inc       = 1'b1;
                state_nx  = last ? S_DONE : S_FILL;
            end
            // read data lags the address by one cycle, so the first read has nothing to add yet
            S_SUM_RD: begin
                mem_addr = src_addr;
                inc      = 1'b1;
                acc_nx   = first ? acc : acc + mem_rdata;
                state_nx = last ? S_SUM_TAIL : S_SUM_RD;
            end
            S_SUM_TAIL: begin
                acc_nx   = acc + mem_rdata;
                state_nx = S_DONE;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            result <= '0;
            fill_r <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            if (load) fill_r <= fill_val;
            if (state_nx == S_DONE && state != S_DONE) result <= acc_nx;
        end
    end

    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
endmodule

// File: tb/tb_dmem_dma_engine.sv
// tb_dmem_dma_engine: directed table-driven bench with a behavioural registered-read memory
module tb_dmem_dma_engine;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0]  mode = '0;
    logic [15:0] src = '0, dst = '0, len = '0, fill_val = '0;
    logic        busy, done, mem_wen;
    logic [15:0] result, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] mem [0:65535];
    logic        tb_we = 1'b0;
    logic [15:0] tb_wa = '0, tb_wd = '0;
    int checks = 0, errors = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] src, dst, len, fill;
        int          cycles;
        logic [31:0] wen_mask;
        logic        chk_res;
        logic [15:0] res;
    } vec_t;
    vec_t tv [5];

    dmem_dma_engine dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_val(fill_val), .busy(busy), .done(done), .result(result),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_we) mem[tb_wa] <= tb_wd;
        else if (mem_wen) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic issue(input logic [1:0] m, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [15:0] f);
        @(negedge clk);
        mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input vec_t v, output int cyc, output logic [31:0] mask);
        issue(v.mode, v.src, v.dst, v.len, v.fill);
        cyc = 0; mask = '0;
        for (int k = 1; k <= 40; k++) begin
            if (mem_wen && k <= 32) mask[k-1] = 1'b1;
            if (done) begin
                cyc = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, dn;
        logic [31:0] mask;
        tv[0] = '{2'd0, 16'h0010, 16'h0040, 16'd4, 16'h0000, 9, 32'hAA, 1'b0, 16'h0};
        tv[1] = '{2'd1, 16'h0000, 16'hFFFE, 16'd3, 16'hA5A5, 4, 32'h07, 1'b0, 16'h0};
        tv[2] = '{2'd0, 16'h0010, 16'h0080, 16'd0, 16'h0000, 1, 32'h00, 1'b0, 16'h0};
        tv[3] = '{2'd3, 16'h0010, 16'h0090, 16'd5, 16'h0000, 1, 32'h00, 1'b0, 16'h0};
        tv[4] = '{2'd2, 16'h0020, 16'h0000, 16'd3, 16'h0000, 5, 32'h00, 1'b1, 16'h0011};

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_result", result, 0);
        for (int a = 0; a < 4; a++) poke(16'h0010 + 16'(a), 16'(a + 1));
        poke(16'h0020, 16'hFFFF); poke(16'h0021, 16'h0002); poke(16'h0022, 16'h0010);
        poke(16'h0080, 16'hBEEF); poke(16'h0090, 16'hBEEF);
        poke(16'h0072, 16'hDEAD); poke(16'h0073, 16'hDEAD); poke(16'h0060, 16'hDEAD);
        rst = 1'b0;

        for (int n = 0; n < 5; n++) begin
            run_op(tv[n], cyc, mask);
            check($sformatf("v%0d_cycles", n), cyc, tv[n].cycles);
            check($sformatf("v%0d_wen_mask", n), mask, tv[n].wen_mask);
            if (tv[n].chk_res) check($sformatf("v%0d_result", n), result, tv[n].res);
            @(negedge clk);
            check($sformatf("v%0d_idle_after", n), {done, busy}, 0);
        end
        for (int a = 0; a < 4; a++) check($sformatf("copy_mem%0d", a), mem[16'h0040 + 16'(a)], a + 1);
        check("fill_fffe", mem[16'hFFFE], 16'hA5A5);
        check("fill_ffff", mem[16'hFFFF], 16'hA5A5);
        check("fill_0000", mem[16'h0000], 16'hA5A5);
        check("len0_untouched", mem[16'h0080], 16'hBEEF);
        check("mode3_untouched", mem[16'h0090], 16'hBEEF);

        // reset after two words of a four-word copy
        issue(2'd0, 16'h0010, 16'h0070, 16'd4, 16'h0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_wen", mem_wen, 0);
        check("abort_result", result, 0);
        rst = 1'b0;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || mem_wen) dn++;
        end
        check("abort_quiet", dn, 0);
        check("abort_mem70", mem[16'h0070], 16'h0001);
        check("abort_mem71", mem[16'h0071], 16'h0002);
        check("abort_mem72", mem[16'h0072], 16'hDEAD);
        check("abort_mem73", mem[16'h0073], 16'hDEAD);

        // second start mid-copy must be ignored
        issue(2'd0, 16'h0010, 16'h0050, 16'd4, 16'h0);
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                cyc = k;
                break;
            end
            if (k == 3) begin
                mode = 2'd1; dst = 16'h0060; len = 16'd1; fill_val = 16'h1234; start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("midstart_cycles", cyc, 9);
        for (int a = 0; a < 4; a++) check($sformatf("midstart_mem%0d", a), mem[16'h0050 + 16'(a)], a + 1);
        check("midstart_fill_ignored", mem[16'h0060], 16'hDEAD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_dma_engine.md
Name: dmem_dma_engine

Overview:
- Bus-master engine on the data-memory port: drives address, write enable and write data, and consumes the memory's registered-address read data.
- Performs block operations on the data memory: COPY (src to dst), FILL (constant to dst) and SUM (checksum of a src range).
- Sits beside the core; an external mux gives it the data-memory port while busy=1.
- Memory timing contract: an address driven in cycle t yields mem_rdata in cycle t+1. Writes commit at the posedge ending the cycle in which mem_wen=1.

Parameters:
- AW, 16: address width; equals the codebase ISIZE.
- DW, 16: data width; equals the codebase DSIZE.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle command strobe; sampled only in IDLE.
- mode  in  2  0=COPY, 1=FILL, 2=SUM, 3=reserved (treated as zero-length, goes straight to DONE).
- src  in  AW  source base address, latched on start.
- dst  in  AW  destination base address, latched on start.
- len  in  AW  word count, latched on start.
- fill_val  in  DW  FILL pattern, latched on start.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- result  out  DW  SUM result; holds until the next accepted start.
- mem_addr  out  AW  memory address.
- mem_wen  out  1  memory write enable, active-high.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, one cycle after mem_addr.

Behaviour:
- Reset: state=IDLE; busy, done, mem_wen = 0; mem_addr, mem_wdata, result, counters = 0.
- Reset asserted mid-operation aborts immediately at that edge. No further writes are issued, no done pulse is produced, and result is cleared.
- FSM states: IDLE, CP_RD, CP_WR, FILL, SUM_RD, SUM_TAIL, DONE.
- IDLE:
  - start=1 latches src, dst, len, fill_val and mode; clears index i and the accumulator.
  - Next state by mode: len=0 or mode=3 -> DONE; COPY -> CP_RD; FILL -> FILL; SUM -> SUM_RD.
- COPY (2 cycles/word):
  - CP_RD: mem_addr=src+i, mem_wen=0.
  - CP_WR: mem_addr=dst+i, mem_wen=1, mem_wdata=mem_rdata; i++.
  - From CP_WR: go to DONE when i==len-1, else back to CP_RD.
  - Copy is strictly ascending, word by word. Overlapping ranges with dst>src propagate already-copied data; this is the defined behaviour.
- FILL (1 cycle/word): mem_addr=dst+i, mem_wen=1, mem_wdata=fill_val; i++; go to DONE after word len-1.
- SUM (pipelined):
  - SUM_RD: mem_addr=src+i each cycle; the accumulator adds mem_rdata in every SUM_RD cycle except the first.
  - After issuing address len-1, go to SUM_TAIL.
  - SUM_TAIL: add the final mem_rdata, then go to DONE.
  - result is loaded from the accumulator on entry to DONE.
- Address arithmetic wraps modulo 2^AW. The sum wraps modulo 2^DW.
- Busy-cycle counts from the start edge to the DONE state: COPY 2*len, FILL len, SUM len+1. DONE lasts exactly 1 cycle, then IDLE.
- start while busy=1 is ignored, with no side effects.
- In IDLE and DONE: mem_wen=0 and mem_addr=0.
- mem_wen is never asserted outside CP_WR and FILL.

Decomposition:
- Shared package or define file: AW/DW tied to ISIZE/DSIZE, mode encodings, FSM state encodings.
- One sub-module, dmem_dma_addr_gen: holds base+index registers, the increment logic and the last-word compare. The FSM and datapath stay in the top module.

Test Plan:
- Reset: rst held for 2 cycles -> busy=0, done=0, mem_wen=0, mem_addr=0, result=0.
- COPY: mem[0x10..0x13]=1,2,3,4; start mode=0, src=0x10, dst=0x40, len=4 -> mem[0x40..0x43]=1,2,3,4; done pulses exactly 9 cycles after the start edge (8 busy cycles plus DONE); mem_wen high in alternate cycles only.
- FILL with wrap: start mode=1, dst=0xFFFE, len=3, fill_val=0xA5A5 -> mem[0xFFFE], mem[0xFFFF], mem[0x0000] all equal 0xA5A5; 3 write cycles.
- SUM: mem[0x20..0x22]=0xFFFF,0x0002,0x0010; start mode=2, src=0x20, len=3 -> result=0x0011 (wrapped); done 5 cycles after start; mem_wen never high.
- Edge cases: len=0 -> done the cycle after start, no memory access. start pulsed again mid-COPY -> ignored and the original copy completes.
- Reset mid-COPY after 2 words of a len=4 copy -> only dst+0 and dst+1 written, no done pulse, busy=0 the next cycle.
